flip_index_serializer: RTL



---
 rtl/flip_index_serializer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/flip_index_serializer.sv
// flip_index_serializer: takes one flipped-spin mask per transaction and streams the index of
// every set bit, one per cycle, over a valid/ready interface. The number of flips is reported
// once the mask has been fully drained.
//
// Build option: define FLIP_SERIALIZER_MSB_FIRST_EN to emit indices from the highest set bit
// downwards. By default, indices ascend from the LSB. Count, latency and handshake behaviour
// are the same in both builds.
module flip_index_serializer #(
  parameter int unsigned  DATAWIDTH = 256,
  localparam int unsigned IDXW      = $clog2(DATAWIDTH),
  localparam int unsigned CNTW      = $clog2(DATAWIDTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 mask_valid_i,
  output logic                 mask_ready_o,
  input  logic [DATAWIDTH-1:0] flip_mask_i,
  output logic                 idx_valid_o,
  input  logic                 idx_ready_i,
  output logic [IDXW-1:0]      idx_o,
  output logic                 idx_last_o,
  output logic                 count_valid_o,
  output logic [CNTW-1:0]      flip_count_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e               state_q;
  logic [DATAWIDTH-1:0] rem_q;
  logic [CNTW-1:0]      count_q;
  logic                 idx_valid_q;
  logic [IDXW-1:0]      idx_q;
  logic                 idx_last_q;
  logic                 count_valid_q;
  logic [CNTW-1:0]      flip_count_q;

  logic [DATAWIDTH-1:0] rem_clr;
  logic [DATAWIDTH-1:0] sel;
  logic [IDXW-1:0]      pick_idx;
  logic                 pick_last;

  // Select the bit to present next: from the incoming mask when idle, otherwise from the
  // remaining mask with the currently presented bit already removed.
  always_comb begin
    rem_clr   = rem_q & ~(DATAWIDTH'(1) << idx_q);
    sel       = (state_q == StIdle) ? flip_mask_i : rem_clr;
    pick_idx  = '0;
`ifdef FLIP_SERIALIZER_MSB_FIRST_EN
    // Ascending sweep so the highest set bit wins.
    for (int i = 0; i < int'(DATAWIDTH); i++) begin
      if (sel[i]) pick_idx = IDXW'(i);
    end
`else
    // Descending sweep so the lowest set bit wins.
    for (int i = int'(DATAWIDTH) - 1; i >= 0; i--) begin
      if (sel[i]) pick_idx = IDXW'(i);
    end
`endif
    // Exactly one bit set: non-zero and clearing the lowest bit leaves nothing.
    pick_last = (sel != '0) && ((sel & (sel - DATAWIDTH'(1))) == '0);
  end

  // Transaction FSM with registered stream and count outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      state_q       <= StIdle;
      rem_q         <= '0;
      count_q       <= '0;
      idx_valid_q   <= 1'b0;
      idx_q         <= '0;
      idx_last_q    <= 1'b0;
      count_valid_q <= 1'b0;
      flip_count_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          count_valid_q <= 1'b0;
          if (mask_valid_i) begin
            rem_q   <= flip_mask_i;
            count_q <= '0;
            if (flip_mask_i != '0) begin
              state_q     <= StScan;
              idx_valid_q <= 1'b1;
              idx_q       <= pick_idx;
              idx_last_q  <= pick_last;
            end else begin
              // Nothing to emit: report a zero count straight away.
              state_q       <= StDone;
              count_valid_q <= 1'b1;
              flip_count_q  <= '0;
            end
          end
        end
        StScan: begin
          if (idx_ready_i) begin
            rem_q   <= rem_clr;
            count_q <= count_q + CNTW'(1);
            if (idx_last_q) begin
              state_q       <= StDone;
              idx_valid_q   <= 1'b0;
              idx_q         <= '0;
              idx_last_q    <= 1'b0;
              count_valid_q <= 1'b1;
              flip_count_q  <= count_q + CNTW'(1);
            end else begin
              idx_q      <= pick_idx;
              idx_last_q <= pick_last;
            end
          end
        end
        StDone: begin
          state_q       <= StIdle;
          count_valid_q <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // en_i gates acceptance combinationally so an abort cycle never takes a mask.
  assign mask_ready_o  = en_i && (state_q == StIdle);
  assign idx_valid_o   = idx_valid_q;
  assign idx_o         = idx_q;
  assign idx_last_o    = idx_last_q;
  assign count_valid_o = count_valid_q;
  assign flip_count_o  = flip_count_q;
  assign busy_o        = (state_q != StIdle);

endmodule
